// File: rtl/tuner_iq_mixer.sv
// tuner_iq_mixer: complex tuner mixer with an integrated NCO.
// Each accepted sample is rotated by e^(-j*theta) (down) or e^(+j*theta) (up),
// where theta comes from a phase accumulator plus a static offset and the
// quadrature LO is built from a quarter-wave sine table. Six pipeline stages,
// one sample per clock, no backpressure, rounded and saturated outputs.
module tuner_iq_mixer #(
  parameter int DSZ        = 16,
  parameter int LOSZ       = 16,
  parameter int PSZ        = 32,
  parameter int LSZ        = 10,
  parameter int COMPLEX_IN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PSZ-1:0]        freq,
  input  logic [PSZ-1:0]        phase_ofs,
  input  logic                  freq_load,
  input  logic                  phase_clr,
  input  logic                  upconv,
  input  logic                  in_valid,
  input  logic signed [DSZ-1:0] in_i,
  input  logic signed [DSZ-1:0] in_q,
  output logic                  out_valid,
  output logic signed [DSZ-1:0] out_i,
  output logic signed [DSZ-1:0] out_q
);

  localparam int PW = DSZ + LOSZ;
  localparam int SW = PW + 1;
  localparam int LUT_DEPTH = 2 ** LSZ;
  localparam int FS = (2 ** (LOSZ - 1)) - 1;
  localparam real PI = 3.14159265358979323846;

  localparam logic signed [SW-1:0] RND    = SW'(2 ** (LOSZ - 2));
  localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (DSZ - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  // Quarter-wave table entry, sampled at half-index offsets so that the
  // reflected index in odd quadrants lands on the mirrored sample exactly.
  function automatic logic [LOSZ-1:0] lut_entry(input int k);
    real ang;
    real val;
    ang = (PI / 2.0) * (real'(k) + 0.5) / real'(LUT_DEPTH);
    val = real'(FS) * $sin(ang) + 0.5;
    return LOSZ'($rtoi(val));
  endfunction

  // Clamp a scaled sum to the signed output range.
  function automatic logic signed [DSZ-1:0] saturate(input logic signed [SW-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[DSZ-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[DSZ-1:0];
    end else begin
      return v[DSZ-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------
  // Quarter-wave sine ROM, filled at elaboration
  // ---------------------------------------------------------------------
  logic [LOSZ-1:0] sin_lut [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [LOSZ-1:0] ENTRY = lut_entry(k);
    assign sin_lut[k] = ENTRY;
  end

  // ---------------------------------------------------------------------
  // Control registers and phase accumulator
  // ---------------------------------------------------------------------
  logic [PSZ-1:0] freq_r;
  logic [PSZ-1:0] phase_ofs_r;
  logic [PSZ-1:0] acc;
  logic [PSZ-1:0] acc_base;
  logic [PSZ-1:0] theta;
  logic signed [DSZ-1:0] q_in;
  logic unused_theta_lsbs;

  // A phase clear coinciding with a sample makes that sample see acc = 0.
  assign acc_base = phase_clr ? '0 : acc;
  assign theta    = acc_base + phase_ofs_r;
  assign q_in     = (COMPLEX_IN != 0) ? in_q : '0;
  assign unused_theta_lsbs = ^theta[PSZ-LSZ-3:0];

  // Frequency word and offset load together; a coincident sample still uses the old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq_r      <= '0;
      phase_ofs_r <= '0;
    end else if (freq_load) begin
      freq_r      <= freq;
      phase_ofs_r <= phase_ofs;
    end
  end

  // Accumulator advances once per accepted sample and wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= acc_base + freq_r;
    end else if (phase_clr) begin
      acc <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // S1: register quadrant and table index of theta with the sample
  // ---------------------------------------------------------------------
  logic                  v1;
  logic                  up1;
  logic signed [DSZ-1:0] i1;
  logic signed [DSZ-1:0] q1;
  logic [1:0]            quad1;
  logic [LSZ-1:0]        idx1;

  // Capture the phase decode inputs alongside the data and direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1    <= 1'b0;
      up1   <= 1'b0;
      i1    <= '0;
      q1    <= '0;
      quad1 <= '0;
      idx1  <= '0;
    end else begin
      v1    <= in_valid;
      up1   <= upconv;
      i1    <= in_i;
      q1    <= q_in;
      quad1 <= theta[PSZ-1 -: 2];
      idx1  <= theta[PSZ-3 -: LSZ];
    end
  end

  // ---------------------------------------------------------------------
  // S2: table reads for sine and cosine (cosine is quadrant + 1)
  // ---------------------------------------------------------------------
  logic [1:0]     cos_quad;
  logic [LSZ-1:0] sin_addr;
  logic [LSZ-1:0] cos_addr;

  // Odd quadrants walk the quarter wave backwards, so the index is inverted.
  always_comb begin
    cos_quad = quad1 + 2'd1;
    sin_addr = idx1;
    cos_addr = idx1;
    if (quad1[0]) begin
      sin_addr = ~idx1;
    end
    if (cos_quad[0]) begin
      cos_addr = ~idx1;
    end
  end

  logic                  v2;
  logic                  up2;
  logic signed [DSZ-1:0] i2;
  logic signed [DSZ-1:0] q2;
  logic [LOSZ-1:0]       sin_mag2;
  logic [LOSZ-1:0]       cos_mag2;
  logic                  sin_neg2;
  logic                  cos_neg2;

  // Register the unsigned magnitudes and the lower-half-plane sign flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2       <= 1'b0;
      up2      <= 1'b0;
      i2       <= '0;
      q2       <= '0;
      sin_mag2 <= '0;
      cos_mag2 <= '0;
      sin_neg2 <= 1'b0;
      cos_neg2 <= 1'b0;
    end else begin
      v2       <= v1;
      up2      <= up1;
      i2       <= i1;
      q2       <= q1;
      sin_mag2 <= sin_lut[sin_addr];
      cos_mag2 <= sin_lut[cos_addr];
      sin_neg2 <= quad1[1];
      cos_neg2 <= cos_quad[1];
    end
  end

  // ---------------------------------------------------------------------
  // S3: apply sign to the LO components
  // ---------------------------------------------------------------------
  logic                   v3;
  logic                   up3;
  logic signed [DSZ-1:0]  i3;
  logic signed [DSZ-1:0]  q3;
  logic signed [LOSZ-1:0] sin3;
  logic signed [LOSZ-1:0] cos3;

  // Magnitudes never exceed full scale, so negation always fits in LOSZ bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3   <= 1'b0;
      up3  <= 1'b0;
      i3   <= '0;
      q3   <= '0;
      sin3 <= '0;
      cos3 <= '0;
    end else begin
      v3   <= v2;
      up3  <= up2;
      i3   <= i2;
      q3   <= q2;
      sin3 <= sin_neg2 ? -$signed(sin_mag2) : $signed(sin_mag2);
      cos3 <= cos_neg2 ? -$signed(cos_mag2) : $signed(cos_mag2);
    end
  end

  // ---------------------------------------------------------------------
  // S4: the four cross products
  // ---------------------------------------------------------------------
  logic                 v4;
  logic                 up4;
  logic signed [PW-1:0] ic4;
  logic signed [PW-1:0] qs4;
  logic signed [PW-1:0] qc4;
  logic signed [PW-1:0] is4;

  // Full-precision signed products of data and LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v4  <= 1'b0;
      up4 <= 1'b0;
      ic4 <= '0;
      qs4 <= '0;
      qc4 <= '0;
      is4 <= '0;
    end else begin
      v4  <= v3;
      up4 <= up3;
      ic4 <= i3 * cos3;
      qs4 <= q3 * sin3;
      qc4 <= q3 * cos3;
      is4 <= i3 * sin3;
    end
  end

  // ---------------------------------------------------------------------
  // S5: combine products; one guard bit keeps the sum exact
  // ---------------------------------------------------------------------
  logic signed [SW-1:0] ic_x;
  logic signed [SW-1:0] qs_x;
  logic signed [SW-1:0] qc_x;
  logic signed [SW-1:0] is_x;

  assign ic_x = $signed({ic4[PW-1], ic4});
  assign qs_x = $signed({qs4[PW-1], qs4});
  assign qc_x = $signed({qc4[PW-1], qc4});
  assign is_x = $signed({is4[PW-1], is4});

  logic                 v5;
  logic signed [SW-1:0] sum_i5;
  logic signed [SW-1:0] sum_q5;

  // Up-conversion flips the sign of the sine terms relative to down-conversion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v5     <= 1'b0;
      sum_i5 <= '0;
      sum_q5 <= '0;
    end else begin
      v5 <= v4;
      if (up4) begin
        sum_i5 <= ic_x - qs_x;
        sum_q5 <= qc_x + is_x;
      end else begin
        sum_i5 <= ic_x + qs_x;
        sum_q5 <= qc_x - is_x;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S6: round half up, rescale by the LO full scale, saturate
  // ---------------------------------------------------------------------
  logic signed [SW-1:0] scaled_i;
  logic signed [SW-1:0] scaled_q;

  // Add half an output LSB before the arithmetic shift to round half up.
  always_comb begin
    scaled_i = '0;
    scaled_q = '0;
    scaled_i = (sum_i5 + RND) >>> (LOSZ - 1);
    scaled_q = (sum_q5 + RND) >>> (LOSZ - 1);
  end

  // Outputs only move on valid results and hold between them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else begin
      out_valid <= v5;
      if (v5) begin
        out_i <= saturate(scaled_i);
        out_q <= saturate(scaled_q);
      end
    end
  end

endmodule

// File: tb/tb_tuner_iq_mixer.sv
// tb_tuner_iq_mixer: directed and randomized checks of tuner_iq_mixer
// against a floating-point NCO/mixer reference model with a scoreboard.
module tb_tuner_iq_mixer;

  localparam real PI = 3.14159265358979323846;
  localparam int  FS = 32767;

  logic               clk;
  logic               reset;
  logic [31:0]        freq;
  logic [31:0]        phase_ofs;
  logic               freq_load;
  logic               phase_clr;
  logic               upconv;
  logic               in_valid;
  logic signed [15:0] in_i;
  logic signed [15:0] in_q;
  logic               out_valid;
  logic signed [15:0] out_i;
  logic signed [15:0] out_q;

  tuner_iq_mixer #(
    .DSZ(16), .LOSZ(16), .PSZ(32), .LSZ(10), .COMPLEX_IN(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .freq      (freq),
    .phase_ofs (phase_ofs),
    .freq_load (freq_load),
    .phase_clr (phase_clr),
    .upconv    (upconv),
    .in_valid  (in_valid),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_i     (out_i),
    .out_q     (out_q)
  );

  typedef struct {
    int due;
    int ei;
    int eq;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          fails;
  int          cyc;
  int          last_i;
  int          last_q;
  logic [31:0] acc_m;
  logic [31:0] freq_m;
  logic [31:0] ofs_m;

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time-stamp expected outputs
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Round to nearest, ties away from zero (table entries are symmetric)
  function automatic int round_sym(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Divide by 2^15 rounding half up, then clamp to 16-bit signed
  function automatic int scale_sat(input longint s);
    longint r;
    longint d;
    r = s + 64'sd16384;
    if (r >= 0) d = r / 32768;
    else d = -((-r + 32767) / 32768);
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return int'(d);
  endfunction

  // Reference mixer: LO sampled at the centre of the 4096-step phase cell
  task automatic mix(input logic [31:0] th, input int i, input int q, input bit up,
                     output int ei, output int eq);
    int     p;
    real    ang;
    longint s;
    longint c;
    p   = int'(th >> 20);
    ang = 2.0 * PI * (real'(p) + 0.5) / 4096.0;
    s   = longint'(round_sym(real'(FS) * $sin(ang)));
    c   = longint'(round_sym(real'(FS) * $cos(ang)));
    if (up) begin
      ei = scale_sat(longint'(i) * c - longint'(q) * s);
      eq = scale_sat(longint'(q) * c + longint'(i) * s);
    end else begin
      ei = scale_sat(longint'(i) * c + longint'(q) * s);
      eq = scale_sat(longint'(q) * c - longint'(i) * s);
    end
  endtask

  function automatic int r16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  // Drive one cycle of inputs (called at a falling edge) and update the model
  task automatic apply_stimulus(input bit v, input int i, input int q, input bit up,
                                input bit fl = 1'b0, input logic [31:0] f = '0,
                                input logic [31:0] o = '0, input bit pc = 1'b0);
    logic [31:0] base;
    exp_t        e;
    in_valid  = v;
    in_i      = 16'(i);
    in_q      = 16'(q);
    upconv    = up;
    freq_load = fl;
    freq      = f;
    phase_ofs = o;
    phase_clr = pc;
    if (v) begin
      base  = pc ? 32'd0 : acc_m;
      mix(base + ofs_m, i, q, up, e.ei, e.eq);
      e.due = cyc + 6;
      sb.push_back(e);
      acc_m = base + freq_m;
    end else if (pc) begin
      acc_m = 32'd0;
    end
    if (fl) begin
      freq_m = f;
      ofs_m  = o;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, r16(), r16(), 1'b0);
  endtask

  // One-cycle reset pulse; outputs must clear on the asserting edge
  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    freq_load = 1'b0;
    phase_clr = 1'b0;
    sb.delete();
    acc_m  = '0;
    freq_m = '0;
    ofs_m  = '0;
    last_i = 0;
    last_q = 0;
    #1;
    checks++;
    assert (out_valid === 1'b0) else begin
      fails++; $error("[TB] FAIL rst_valid observed=%0b expected=0", out_valid);
    end
    checks++;
    assert (out_i === 16'sd0) else begin
      fails++; $error("[TB] FAIL rst_out_i observed=%0d expected=0", out_i);
    end
    checks++;
    assert (out_q === 16'sd0) else begin
      fails++; $error("[TB] FAIL rst_out_q observed=%0d expected=0", out_q);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Output monitor: timing, values, and hold-between-valids
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (out_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0 && sb[0].due == cyc) else begin
        fails++;
        $error("[TB] FAIL out_valid_timing observed_cycle=%0d expected_cycle=%0d",
               cyc, (sb.size() > 0) ? sb[0].due : -1);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert (int'(out_i) === e.ei) else begin
          fails++; $error("[TB] FAIL out_i observed=%0d expected=%0d", out_i, e.ei);
        end
        checks++;
        assert (int'(out_q) === e.eq) else begin
          fails++; $error("[TB] FAIL out_q observed=%0d expected=%0d", out_q, e.eq);
        end
        last_i = e.ei;
        last_q = e.eq;
      end
    end else begin
      checks++;
      assert (!(sb.size() > 0 && sb[0].due <= cyc)) else begin
        fails++;
        $error("[TB] FAIL missing_out_valid observed=%0b expected=1 at cycle %0d", out_valid, cyc);
        void'(sb.pop_front());
      end
      checks++;
      assert (int'(out_i) === last_i && int'(out_q) === last_q) else begin
        fails++;
        $error("[TB] FAIL hold observed=%0d/%0d expected=%0d/%0d", out_i, out_q, last_i, last_q);
      end
    end
  end

  initial begin
    checks    = 0;
    fails     = 0;
    last_i    = 0;
    last_q    = 0;
    acc_m     = '0;
    freq_m    = '0;
    ofs_m     = '0;
    reset     = 1'b1;
    freq      = '0;
    phase_ofs = '0;
    freq_load = 1'b0;
    phase_clr = 1'b0;
    upconv    = 1'b0;
    in_valid  = 1'b0;
    in_i      = '0;
    in_q      = '0;

    // Power-on reset
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    assert (out_valid === 1'b0 && out_i === 16'sd0 && out_q === 16'sd0) else begin
      fails++;
      $error("[TB] FAIL por_state observed=%0b/%0d/%0d expected=0/0/0", out_valid, out_i, out_q);
    end
    reset = 1'b1;
    $display("[TB] reset released");

    // Zero frequency and offset, down mode
    apply_stimulus(1'b1, 16384, 0, 1'b0);
    idle(8);

    // 90 degree offset, down then up
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1, 32'h0, 32'h4000_0000);
    apply_stimulus(1'b1, 16384, 0, 1'b0);
    apply_stimulus(1'b1, 16384, 0, 1'b1);
    idle(7);

    // 45 degree offset: negative and positive saturation
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1, 32'h0, 32'h2000_0000);
    apply_stimulus(1'b1, -32768, -32768, 1'b0);
    apply_stimulus(1'b1, 32767, 32767, 1'b0);
    apply_stimulus(1'b1, -32768, -32768, 1'b1);
    idle(7);

    // Quarter-cycle step, continuous then with 3-cycle gaps
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
    for (int k = 0; k < 8; k++) apply_stimulus(1'b1, 16384, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 16384, 0, 1'b0);
      idle(3);
    end
    idle(7);

    // Phase clear with a sample while acc is non-zero, then coincident load
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1, 32'h1000_0000, 32'h0800_0000);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 20000, -9000, 1'b0);
    apply_stimulus(1'b1, 20000, -9000, 1'b0, 1'b0, '0, '0, 1'b1);
    apply_stimulus(1'b1, 20000, -9000, 1'b0);
    apply_stimulus(1'b1, 12000, 3000, 1'b1, 1'b1, 32'h2000_0000, 32'h0400_0000);
    apply_stimulus(1'b1, 12000, 3000, 1'b1);
    apply_stimulus(1'b1, 12000, 3000, 1'b1);
    idle(7);

    // Randomized traffic with occasional reloads and clears
    for (int n = 0; n < 250; n++) begin
      apply_stimulus(($urandom_range(0, 3) != 0), r16(), r16(), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 15) == 0), $urandom, $urandom,
                     ($urandom_range(0, 19) == 0));
    end
    idle(7);

    // Reset pulse mid-burst: in-flight samples discarded, NCO restarts at 0
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1, 32'h1234_5678, 32'h0abc_def0);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, r16(), r16(), 1'b0);
    do_reset();
    apply_stimulus(1'b1, 16384, 0, 1'b0);
    for (int k = 0; k < 5; k++) apply_stimulus(1'b1, r16(), r16(), 1'b0);
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b1, 32'h0800_0000, 32'h0);
    for (int k = 0; k < 6; k++) apply_stimulus(1'b1, r16(), r16(), 1'b1);

    // Drain with a bounded wait
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      apply_stimulus(1'b0, 0, 0, 1'b0);
    end
    idle(2);
    checks++;
    assert (sb.size() == 0) else begin
      fails++; $error("[TB] FAIL drain observed_pending=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
